scu_dispatcher: RTL
===================

// Module: scu_dispatcher
// PURPOSE
//   Upstream feeder for the Streaming Compute Unit (SCU). Buffers layer jobs
//   (job id + total multiplications) in a small FIFO and splits each job into
//   chunks of at most CHUNK_MULTS. Issues chunks one at a time on the SCU
//   start/assigned_mults interface, sums the SCU cycles_used per chunk, and
//   returns one result per job (id, total cycles, chunk count) over valid/ready.
// PARAMETERS
//   MULT_WIDTH      32    width of multiplication counts and cycle totals
//   ID_WIDTH        8     job identifier width
//   FIFO_DEPTH      4     job FIFO entries; power of 2, >= 2
//   CHUNK_MULTS     1152  max multiplications per SCU start; must be > 0
//   TIMEOUT_CYCLES  4096  SCU done watchdog limit (DISPATCH_TIMEOUT_EN only)
// PORTS
//   clk                 in   1           clock, rising edge
//   rst                 in   1           synchronous reset, active high
//   job_valid           in   1           job offered
//   job_ready           out  1           !fifo_full (combinational)
//   job_mults           in   MULT_WIDTH  total multiplications for the job
//   job_id              in   ID_WIDTH    job tag
//   scu_start           out  1           one-cycle start pulse to the SCU
//   scu_assigned_mults  out  MULT_WIDTH  chunk size; valid while scu_start=1
//   scu_busy            in   1           SCU busy
//   scu_done            in   1           SCU one-cycle done pulse
//   scu_cycles_used     in   MULT_WIDTH  SCU cycles for the chunk; sampled on scu_done
//   res_valid           out  1           result available
//   res_ready           in   1           result consumer ready
//   res_id              out  ID_WIDTH    job tag of the result
//   res_cycles          out  MULT_WIDTH  summed SCU cycles; saturates at all-ones
//   res_chunks          out  MULT_WIDTH  number of SCU starts issued for the job
//   idle                out  1           FSM in IDLE and FIFO empty
//   timeout_err         out  1           sticky watchdog flag (DISPATCH_TIMEOUT_EN only)
// BEHAVIOUR
//   Reset: FIFO emptied; FSM=IDLE; scu_start, res_valid, timeout_err = 0;
//     res_id, res_cycles, res_chunks, scu_assigned_mults = 0; idle = 1.
//     Pushes while rst=1 are ignored.
//   FIFO: push on job_valid&&job_ready. Push and pop in the same cycle are
//     legal; count is unchanged. No push when full.
//   FSM states: IDLE, ISSUE, WAIT, REPORT.
//   - IDLE: if FIFO not empty, pop into working regs: rem=mults, acc=0,
//     chunks=0. Go to REPORT if mults==0, otherwise go to ISSUE.
//     Zero-mult jobs never start the SCU.
//   - ISSUE: if !scu_busy, drive scu_start=1 for exactly one cycle with
//     chunk=min(rem,CHUNK_MULTS). Then rem-=chunk, chunks+=1, go to WAIT.
//     If scu_busy, hold in ISSUE.
//   - WAIT: on scu_done, acc=sat(acc+scu_cycles_used). Go to REPORT if
//     rem==0, otherwise go to ISSUE.
//   - REPORT: res_valid=1 with fields stable until res_ready. On the
//     handshake, res_valid drops the next cycle and the FSM goes to IDLE.
//   Latency: push in cycle N gives scu_start in cycle N+2 when the FSM is
//     idle. Each chunk has one ISSUE cycle.
//   scu_done outside WAIT is ignored. This covers a stale done after reset.
//   Reset mid-operation: the working job and FIFO contents are dropped and
//     no result is emitted for them.
//   Arithmetic: unsigned. acc saturates and does not wrap. chunks cannot
//     overflow because chunks <= job_mults.
// CONFIGURATION
//   DISPATCH_TIMEOUT_EN defined:
//   - A WAIT cycle counter clears on each scu_start.
//   - When it reaches TIMEOUT_CYCLES with no scu_done: timeout_err<=1
//     (sticky until rst), remaining chunks are abandoned, and the FSM goes to
//     REPORT with res_cycles=all-ones.
//   DISPATCH_TIMEOUT_EN undefined: timeout_err port and counter are absent;
//     WAIT lasts until scu_done.
// TESTING  (SCU model with 18 multipliers, defaults)
//   1. job id=5, mults=3000 -> starts of 1152,1152,696; res_id=5,
//      res_cycles=64+64+39=167, res_chunks=3.
//   2. job mults=0 id=9 -> no scu_start; res_cycles=0, res_chunks=0 within 3 cycles.
//   3. res_ready=0, push 6 jobs back to back -> 5 accepted (1 working + 4 FIFO),
//      job_ready=0 afterwards; drain restores job_ready; results come out in order.
//   4. res_ready low for 10 cycles in REPORT -> res_* stable, no scu_start,
//      FIFO still accepts while not full.
//   5. rst pulse during WAIT, then stale scu_done -> outputs at reset values,
//      done ignored; next job mults=18 gives res_cycles=1.
//   6. DISPATCH_TIMEOUT_EN, SCU never returns done -> timeout_err=1 exactly 4096
//      cycles after scu_start; res_cycles=32'hFFFFFFFF.

Source files
------------

// File: rtl/scu_dispatcher.sv
// scu_dispatcher: buffers jobs, splits them into SCU-sized chunks and reports summed cycles per job.
// Optional SCU done watchdog is compiled in with DISPATCH_TIMEOUT_EN.
module scu_dispatcher #(
  parameter int MULT_WIDTH     = 32,
  parameter int ID_WIDTH       = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int CHUNK_MULTS    = 1152,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [MULT_WIDTH-1:0] job_mults,
  input  logic [ID_WIDTH-1:0]   job_id,
  output logic                  scu_start,
  output logic [MULT_WIDTH-1:0] scu_assigned_mults,
  input  logic                  scu_busy,
  input  logic                  scu_done,
  input  logic [MULT_WIDTH-1:0] scu_cycles_used,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ID_WIDTH-1:0]   res_id,
  output logic [MULT_WIDTH-1:0] res_cycles,
  output logic [MULT_WIDTH-1:0] res_chunks,
  output logic                  idle
`ifdef DISPATCH_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [MULT_WIDTH-1:0] ONE = 1;
  localparam logic [MULT_WIDTH-1:0] CHUNK = MULT_WIDTH'(CHUNK_MULTS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_e;

  state_e                state_q, state_d;
  logic [MULT_WIDTH-1:0] fifo_mults_q [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   fifo_id_q [FIFO_DEPTH];
  logic [AW:0]           wr_q, rd_q;
  logic                  empty, push, pop, tmo_hit;
  logic [MULT_WIDTH-1:0] rem_q, rem_d, acc_q, acc_d, chunks_q, chunks_d, chunk, head_mults;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [MULT_WIDTH:0]   sum;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CHUNK_MULTS < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("scu_dispatcher: illegal parameter set");
  end

  // Extra pointer bit distinguishes full from empty.
  assign empty      = wr_q == rd_q;
  assign job_ready  = !(wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push       = job_valid && job_ready;
  assign pop        = state_q == IDLE && !empty;
  assign head_mults = fifo_mults_q[rd_q[AW-1:0]];
  assign chunk      = rem_q > CHUNK ? CHUNK : rem_q;
  assign sum        = {1'b0, acc_q} + {1'b0, scu_cycles_used};
  assign res_id     = id_q;
  assign res_cycles = acc_q;
  assign res_chunks = chunks_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_ONE;
      if (pop) rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mults_q[wr_q[AW-1:0]] <= job_mults;
      fifo_id_q[wr_q[AW-1:0]]    <= job_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      acc_q    <= '0;
      chunks_q <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      chunks_q <= chunks_d;
      id_q     <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = head_mults == '0 ? REPORT : ISSUE;
      ISSUE:   if (!scu_busy) state_d = WAIT;
      WAIT:    if (scu_done) state_d = rem_q == '0 ? REPORT : ISSUE;
               else if (tmo_hit) state_d = REPORT;
      REPORT:  if (res_ready) state_d = IDLE;
    endcase
  end

  always_comb begin
    rem_d    = rem_q;
    acc_d    = acc_q;
    chunks_d = chunks_q;
    id_d     = id_q;
    if (pop) begin
      rem_d    = head_mults;
      acc_d    = '0;
      chunks_d = '0;
      id_d     = fifo_id_q[rd_q[AW-1:0]];
    end
    if (scu_start) begin
      rem_d    = rem_q - chunk;
      chunks_d = chunks_q + ONE;
    end
    // Cycle total saturates instead of wrapping; a watchdog abort forces it to all-ones.
    if (state_q == WAIT && scu_done) acc_d = sum[MULT_WIDTH] ? '1 : sum[MULT_WIDTH-1:0];
    else if (tmo_hit) begin
      acc_d = '1;
      rem_d = '0;
    end
  end

  always_comb begin
    scu_start          = state_q == ISSUE && !scu_busy;
    scu_assigned_mults = scu_start ? chunk : '0;
    res_valid          = state_q == REPORT;
    idle               = state_q == IDLE && empty;
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;
  // Flag is visible TIMEOUT_CYCLES cycles after the cycle that carried scu_start.
  assign tmo_hit     = state_q == WAIT && !scu_done && tmo_q == TW'(TIMEOUT_CYCLES - 2);
  assign timeout_err = err_q;
  always_ff @(posedge clk) begin
    if (rst || scu_start) tmo_q <= '0;
    else if (state_q == WAIT) tmo_q <= tmo_q + TW'(1);
    if (rst) err_q <= 1'b0;
    else if (tmo_hit) err_q <= 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif
endmodule
